// File: rtl/weight_fetch_if.sv
// Bundle of command, status, BRAM read-port and weight-stream signals
// shared by the weight fetch controller and its environment.
interface weight_fetch_if #(
  parameter int ADDR  = 16,
  parameter int WIDE  = 4,
  parameter int LEN_W = 16
);
  logic             start;
  logic [ADDR-1:0]  base_addr;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             busy;
  logic             done;
  logic [ADDR-1:0]  bram_addr;
  logic [WIDE-1:0]  bram_dout;
  logic [WIDE-1:0]  w_data;
  logic             w_valid;
  logic             w_ready;
  logic             w_last;

  // Controller side: drives the BRAM address and the weight stream.
  modport master (
    input  start, base_addr, len, abort, bram_dout, w_ready,
    output busy, done, bram_addr, w_data, w_valid, w_last
  );

  // Environment side: scheduler, BRAM and consumer.
  modport slave (
    output start, base_addr, len, abort, bram_dout, w_ready,
    input  busy, done, bram_addr, w_data, w_valid, w_last
  );
endinterface

// File: rtl/weight_fetch_ctrl.sv
// Weight fetch controller: turns (base, len) commands into BRAM reads and
// returns the weights as a valid/ready stream through a 2-entry FIFO.
module weight_fetch_ctrl #(
  parameter int ADDR  = 16,
  parameter int WIDE  = 4,
  parameter int LEN_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  weight_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR-1:0]  bram_addr_reg;
  logic [ADDR-1:0]  next_addr_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] issue_cnt_reg;
  logic             addr_vld_reg;
  logic             addr_last_reg;
  logic             rd_pend_reg;
  logic             pend_last_reg;
  logic [WIDE-1:0]  fifo_data_reg [2];
  logic             fifo_last_reg [2];
  logic             rd_ptr_reg;
  logic             wr_ptr_reg;
  logic [1:0]       count_reg;

  logic       valid;
  logic       head_last;
  logic       pop;
  logic       push;
  logic       issue;
  logic       issue_last;
  logic       cmd_accept;
  logic [1:0] occ;
  logic [1:0] wr_en;

  assign valid      = (count_reg != 2'd0);
  assign head_last  = fifo_last_reg[rd_ptr_reg];
  assign pop        = valid && bus.w_ready;
  // A pending word waits on the BRAM output while the FIFO is full; the
  // address is held then, so the BRAM keeps presenting the same word.
  assign push       = rd_pend_reg && ((count_reg != 2'd2) || pop);
  assign occ        = count_reg + {1'b0, rd_pend_reg};
  assign issue      = (state_reg == FETCH) && !bus.abort &&
                      (pop ? (occ <= 2'd2) : (occ <= 2'd1));
  assign issue_last = (issue_cnt_reg == (len_reg - LEN_W'(1)));
  assign cmd_accept = (state_reg == IDLE) && bus.start && !bus.abort;

  always_comb begin
    state_next = state_reg;
    if (bus.abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (bus.start) state_next = (bus.len == '0) ? DONE : FETCH;
        FETCH:   if (issue && issue_last) state_next = DRAIN;
        DRAIN:   if (pop && head_last) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bram_addr_reg <= '0;
      next_addr_reg <= '0;
      len_reg       <= '0;
      issue_cnt_reg <= '0;
      addr_vld_reg  <= 1'b0;
      addr_last_reg <= 1'b0;
      rd_pend_reg   <= 1'b0;
      pend_last_reg <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      wr_ptr_reg    <= 1'b0;
      count_reg     <= 2'd0;
    end else begin
      state_reg <= state_next;
      if (cmd_accept) begin
        next_addr_reg <= bus.base_addr;
        len_reg       <= bus.len;
        issue_cnt_reg <= '0;
      end
      if (issue) begin
        bram_addr_reg <= next_addr_reg;
        next_addr_reg <= next_addr_reg + ADDR'(1);
        issue_cnt_reg <= issue_cnt_reg + LEN_W'(1);
      end
      if (bus.abort) begin
        addr_vld_reg  <= 1'b0;
        addr_last_reg <= 1'b0;
        rd_pend_reg   <= 1'b0;
        pend_last_reg <= 1'b0;
        rd_ptr_reg    <= 1'b0;
        wr_ptr_reg    <= 1'b0;
        count_reg     <= 2'd0;
      end else begin
        addr_vld_reg  <= issue;
        addr_last_reg <= issue && issue_last;
        if (addr_vld_reg) begin
          rd_pend_reg   <= 1'b1;
          pend_last_reg <= addr_last_reg;
        end else if (push) begin
          rd_pend_reg   <= 1'b0;
        end
        if (push) wr_ptr_reg <= ~wr_ptr_reg;
        if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 2'd1;
          2'b01:   count_reg <= count_reg - 2'd1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      assign wr_en[gi] = push && !bus.abort && (wr_ptr_reg == 1'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          fifo_data_reg[gi] <= '0;
          fifo_last_reg[gi] <= 1'b0;
        end else if (wr_en[gi]) begin
          fifo_data_reg[gi] <= bus.bram_dout;
          fifo_last_reg[gi] <= pend_last_reg;
        end
      end
    end
  endgenerate

  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == DONE);
  assign bus.bram_addr = bram_addr_reg;
  assign bus.w_data    = fifo_data_reg[rd_ptr_reg];
  assign bus.w_valid   = valid;
  assign bus.w_last    = valid && head_last;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: table of transfers, hand-written abort/reset
// sequences and randomized transfers against a queue-based stream model.
module tb_weight_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  weight_fetch_if #(.ADDR(16), .WIDE(4), .LEN_W(16)) bus ();

  weight_fetch_ctrl #(.ADDR(16), .WIDE(4), .LEN_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] d;
    logic       l;
  } beat_t;

  typedef struct {
    logic [15:0] base;
    int          len;
    int          mode;     // 0: ready high, 1: ready 1,0,0 pattern, 2: random
    int          exp_lat;  // edges from start to done, -1 = not checked
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[7];

  int   cmp_count = 0;
  int   err_count = 0;
  bit   mon_en    = 1'b0;
  bit   zero_ok   = 1'b0;
  logic hs_prev   = 1'b0;
  logic stall_prev = 1'b0;
  logic [3:0] stall_d = '0;
  logic stall_l = 1'b0;

  // Memory contents seen through the BRAM port.
  function automatic logic [3:0] wt(input logic [15:0] a);
    logic [3:0] r;
    r = a[3:0] + a[7:4] + a[11:8] + a[15:12] + 4'd3;
    r = r ^ {a[0], a[5], a[10], a[15]};
    return r;
  endfunction

  always @(posedge clk) bus.bram_dout <= wt(bus.bram_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    cmp_count++;
    if (act !== req) begin
      err_count++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"},      32'(bus.busy),      0);
    check({tag, "_done"},      32'(bus.done),      0);
    check({tag, "_bram_addr"}, 32'(bus.bram_addr), 0);
    check({tag, "_w_valid"},   32'(bus.w_valid),   0);
    check({tag, "_w_last"},    32'(bus.w_last),    0);
    check({tag, "_w_data"},    32'(bus.w_data),    0);
  endtask

  // Stream monitor: in-order scoreboard, stall stability, done timing.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (hs_prev)
        check("done_after_last", 32'(bus.done), 1);
      else if (!zero_ok)
        check("no_spurious_done", 32'(bus.done), 0);
      if (stall_prev) begin
        check("stall_valid", 32'(bus.w_valid), 1);
        check("stall_data",  32'(bus.w_data),  32'(stall_d));
        check("stall_last",  32'(bus.w_last),  32'(stall_l));
      end
      if (bus.w_valid && bus.w_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          check("beat_data", 32'(bus.w_data), 32'(exp_q[0].d));
          check("beat_last", 32'(bus.w_last), 32'(exp_q[0].l));
          exp_q.delete(0);
        end
      end
      hs_prev    <= bus.w_valid && bus.w_ready && bus.w_last;
      stall_prev <= bus.w_valid && !bus.w_ready;
      stall_d    <= bus.w_data;
      stall_l    <= bus.w_last;
    end else begin
      hs_prev    <= 1'b0;
      stall_prev <= 1'b0;
    end
  end

  task automatic run_xfer(input logic [15:0] base, input int ln, input int mode, input int exp_lat);
    int    n;
    int    limit;
    bit    seen;
    beat_t b;
    logic [15:0] a;
    limit = 40 * ln + 40;
    for (int i = 0; i < ln; i++) begin
      a   = base + 16'(i);
      b.d = wt(a);
      b.l = (i == ln - 1);
      exp_q.push_back(b);
    end
    zero_ok = (ln == 0);
    cyc();
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.len       = 16'(ln);
    cyc();
    bus.start     = 1'b0;
    bus.base_addr = 16'($urandom);
    bus.len       = 16'($urandom);
    seen = 1'b0;
    for (n = 0; n < limit; n++) begin
      if (n > 0) cyc();
      case (mode)
        0:       bus.w_ready = 1'b1;
        1:       bus.w_ready = (n % 3 == 0);
        default: begin
          bus.w_ready   = ($urandom_range(0, 3) != 0);
          bus.start     = ($urandom_range(0, 7) == 0);
          bus.base_addr = 16'($urandom);
          bus.len       = 16'($urandom_range(0, 30));
        end
      endcase
      @(negedge clk);
      if (n == 0) check("busy_after_start", 32'(bus.busy), 1);
      if (ln == 0) check("len0_no_valid", 32'(bus.w_valid), 0);
      if (mode == 0 && n >= 1 && n <= ln) begin
        a = base + 16'(n - 1);
        check("issue_addr", 32'(bus.bram_addr), 32'(a));
      end
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    check("done_seen", 32'(seen), 1);
    if (exp_lat >= 0) check("done_latency", n, exp_lat);
    check("busy_with_done", 32'(bus.busy), 1);
    cyc();
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 0);
    check("busy_cleared",   32'(bus.busy), 0);
    check("beats_left",     exp_q.size(), 0);
    exp_q.delete();
    zero_ok = 1'b0;
    $display("xfer base=%04h len=%0d mode=%0d done_at=%0d", base, ln, mode, n);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rb;
    int          rl;
    int          rm;

    vecs[0] = '{16'h0010, 4,  0, 7};
    vecs[1] = '{16'hFFFE, 4,  0, 7};
    vecs[2] = '{16'h0200, 0,  0, 0};
    vecs[3] = '{16'h0300, 6,  1, -1};
    vecs[4] = '{16'h1234, 1,  0, 4};
    vecs[5] = '{16'h8000, 9,  1, -1};
    vecs[6] = '{16'hFFF0, 20, 0, 23};

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.len       = '0;
    bus.abort     = 1'b0;
    bus.w_ready   = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    check_reset_vals("reset");
    cyc();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int v = 0; v < 7; v++)
      run_xfer(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].exp_lat);

    // Abort while reads are in flight; late BRAM data must be dropped.
    mon_en = 1'b0;
    cyc();
    bus.start = 1'b1; bus.base_addr = 16'h0400; bus.len = 16'd10; bus.w_ready = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (3) cyc();
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_fetch_valid", 32'(bus.w_valid), 0);
    check("abort_fetch_busy",  32'(bus.busy),    0);

    // Abort in DRAIN with the consumer stalled.
    cyc();
    bus.start = 1'b1; bus.base_addr = 16'h0100; bus.len = 16'd2; bus.w_ready = 1'b0;
    cyc();
    bus.start = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    check("drain_pre_valid", 32'(bus.w_valid), 1);
    check("drain_pre_busy",  32'(bus.busy),    1);
    cyc();
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_drain_valid", 32'(bus.w_valid), 0);
    check("abort_drain_busy",  32'(bus.busy),    0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      check("abort_no_done",  32'(bus.done),    0);
      check("abort_no_valid", 32'(bus.w_valid), 0);
    end

    // Abort wins over a simultaneous start.
    cyc();
    bus.abort = 1'b1; bus.start = 1'b1; bus.len = 16'd5;
    cyc();
    bus.abort = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check("abort_over_start", 32'(bus.busy), 0);

    mon_en = 1'b1;
    run_xfer(16'h0100, 3, 0, 6);

    // Asynchronous reset in the middle of a fetch.
    mon_en = 1'b0;
    cyc();
    bus.start = 1'b1; bus.base_addr = 16'h0500; bus.len = 16'd12; bus.w_ready = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (3) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    run_xfer(16'h0500, 5, 0, 8);

    for (int r = 0; r < 25; r++) begin
      rb = 16'($urandom);
      rl = $urandom_range(1, 24);
      rm = (r % 5 == 0) ? 0 : ((r % 5 == 1) ? 1 : 2);
      run_xfer(rb, rl, rm, (rm == 0) ? rl + 3 : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
